// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared types and helpers for the motor command sequencer.
//   sm_cmd_t      : sign-magnitude speed word ([7]=sign, 1=reverse; [6:0]=mag)
//   chan_state_t  : per-channel sequencing state (RUN / DWELL / HALT)
//   sm_to_signed  : sign-magnitude -> two's complement (-0 maps to 0)
//   signed_to_sm  : two's complement -> sign-magnitude (0 always has sign=0)
//   clamp_sm      : limit a magnitude to a ceiling; a clamped zero loses its sign
// ---------------------------------------------------------------------------
package motor_pkg;

    typedef struct packed {
        logic       sign;
        logic [6:0] mag;
    } sm_cmd_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWELL = 2'd1,
        HALT  = 2'd2
    } chan_state_t;

    function automatic logic signed [7:0] sm_to_signed(input sm_cmd_t c);
        logic signed [7:0] m;
        m = $signed({1'b0, c.mag});
        return c.sign ? -m : m;
    endfunction

    function automatic sm_cmd_t signed_to_sm(input logic signed [7:0] v);
        sm_cmd_t r;
        r.sign = v[7];
        r.mag  = v[7] ? 7'(-v) : v[6:0];
        return r;
    endfunction

    // Negative zero is folded to +0 here so that downstream a zero target
    // never carries a reverse direction.
    function automatic sm_cmd_t clamp_sm(input sm_cmd_t c, input logic [6:0] max_mag);
        sm_cmd_t r;
        r.mag  = (c.mag > max_mag) ? max_mag : c.mag;
        r.sign = c.sign && (r.mag != 7'd0);
        return r;
    endfunction

endpackage

// File: rtl/motor_slew_channel.sv
// ---------------------------------------------------------------------------
// motor_slew_channel
// One motor's setpoint sequencer: slew limiting toward a target, a zero-speed
// dwell after every nonzero->zero transition, and an e-stop hold.
//   clk, reset   : clock, asynchronous active-low reset
//   step_tick    : one-cycle timebase strobe; slew and dwell advance only here
//   estop        : level; forces HALT and zero output on the next edge
//   resume       : one-cycle strobe; an accepted command that releases HALT
//   target       : clamped sign-magnitude target
//   setpoint     : registered sign-magnitude applied value
//   changed      : setpoint will differ after the coming edge
//   state        : current FSM state, exported for observation
// ---------------------------------------------------------------------------
module motor_slew_channel
    import motor_pkg::*;
#(
    parameter int SLEW_STEP  = 4,
    parameter int DEAD_TICKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_tick,
    input  logic        estop,
    input  logic        resume,
    input  sm_cmd_t     target,
    output sm_cmd_t     setpoint,
    output logic        changed,
    output chan_state_t state
);

    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [DW-1:0]     DWELL_LAST = DW'(DEAD_TICKS - 1);
    localparam logic signed [8:0] STEP_S     = 9'(SLEW_STEP);

    logic signed [7:0] cur;
    logic signed [7:0] tgt_s;
    logic signed [7:0] eff;
    logic signed [7:0] ramp_val;
    logic signed [7:0] cur_next;
    logic signed [8:0] diff;
    logic signed [8:0] diff_lim;
    logic [DW-1:0]     dwell_cnt;
    sm_cmd_t           sp_next;

    always_comb begin
        tgt_s = sm_to_signed(target);

        // A reversal request first drives the channel to zero; the dwell
        // then follows from the nonzero->zero transition.
        eff = tgt_s;
        if ((cur > 8'sd0 && tgt_s < 8'sd0) || (cur < 8'sd0 && tgt_s > 8'sd0)) begin
            eff = '0;
        end

        // 9-bit difference so that -100 - (+100) cannot wrap.
        diff     = {eff[7], eff} - {cur[7], cur};
        diff_lim = diff;
        if (diff > STEP_S) begin
            diff_lim = STEP_S;
        end else if (diff < -STEP_S) begin
            diff_lim = -STEP_S;
        end
        ramp_val = cur + 8'(diff_lim);

        // DWELL and HALT keep cur at zero, so only RUN moves it.
        cur_next = cur;
        if (estop) begin
            cur_next = '0;
        end else if (state == RUN && step_tick) begin
            cur_next = ramp_val;
        end

        sp_next = signed_to_sm(cur_next);
        changed = (sp_next != setpoint);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            cur       <= '0;
            dwell_cnt <= '0;
            setpoint  <= '0;
        end else begin
            cur      <= cur_next;
            setpoint <= sp_next;
            if (estop) begin
                state <= HALT;
            end else begin
                case (state)
                    RUN: begin
                        if (step_tick && cur != 8'sd0 && ramp_val == 8'sd0) begin
                            state     <= DWELL;
                            dwell_cnt <= '0;
                        end
                    end
                    DWELL: begin
                        if (step_tick) begin
                            if (dwell_cnt == DWELL_LAST) begin
                                state <= RUN;
                            end
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    HALT: begin
                        // Leaves with cur already zero and no dwell.
                        if (resume) begin
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// motor_cmd_sequencer
// Converts SPI sign-magnitude speed commands into slew-limited, reversal-safe
// setpoints for a two-channel H-bridge PWM controller.
//   clk, reset        : clock, asynchronous active-low reset
//   cmd_valid         : command frame strobe
//   cmd_motor1/2      : [7]=sign (1=reverse), [6:0]=magnitude
//   estop             : level; immediate stop and hold while high
//   motor1/2_sign/mag : registered applied setpoints
//   load              : one-cycle strobe in the first cycle new setpoints show
//   timeout_flag      : set on watchdog expiry, cleared by an accepted command
//   halted            : e-stop hold in effect
//
// Handshake: cmd_valid is a single-cycle strobe with no backpressure. A frame
// is accepted on any rising edge where cmd_valid=1 and estop=0; with estop=1
// it is dropped. While halted, the first accepted frame also ends the hold.
// ---------------------------------------------------------------------------
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int STEP_DIV   = 1000,
    parameter int SLEW_STEP  = 4,
    parameter int DEAD_TICKS = 8,
    parameter int WDT_STEPS  = 500,
    parameter int MAX_MAG    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_motor1,
    input  logic [7:0] cmd_motor2,
    input  logic       estop,
    output logic       motor1_sign,
    output logic [6:0] motor1_mag,
    output logic       motor2_sign,
    output logic [6:0] motor2_mag,
    output logic       load,
    output logic       timeout_flag,
    output logic       halted
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int WW = (WDT_STEPS > 1) ? $clog2(WDT_STEPS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
    localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_STEPS - 1);
    localparam logic [6:0]    MAX_MAG_7 = 7'(MAX_MAG);

    logic [PW-1:0] pre_cnt;
    logic [WW-1:0] wdt_cnt;
    logic          step_tick;
    logic          accept;
    logic          wdt_expire;
    sm_cmd_t       tgt1;
    sm_cmd_t       tgt2;
    sm_cmd_t       sp1;
    sm_cmd_t       sp2;
    logic          chg1;
    logic          chg2;
    chan_state_t   ch1_state;
    chan_state_t   ch2_state;

    assign step_tick = (pre_cnt == PRE_LAST);
    assign accept    = cmd_valid && !estop;
    // The watchdog stops counting once expired; only a command restarts it.
    assign wdt_expire = step_tick && !timeout_flag && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (step_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Priority: e-stop clears targets, then a fresh command, then expiry.
    // A command on the expiry cycle therefore wins and the flag stays low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt1         <= '0;
            tgt2         <= '0;
            wdt_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (estop) begin
                tgt1 <= '0;
                tgt2 <= '0;
            end else if (accept) begin
                tgt1 <= clamp_sm(sm_cmd_t'(cmd_motor1), MAX_MAG_7);
                tgt2 <= clamp_sm(sm_cmd_t'(cmd_motor2), MAX_MAG_7);
            end else if (wdt_expire) begin
                tgt1 <= '0;
                tgt2 <= '0;
            end

            if (accept) begin
                wdt_cnt      <= '0;
                timeout_flag <= 1'b0;
            end else if (wdt_expire) begin
                wdt_cnt      <= '0;
                timeout_flag <= 1'b1;
            end else if (step_tick && !timeout_flag) begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
        end
    end

    // load is registered alongside the setpoints, so it is high exactly in
    // the first cycle the new values are presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load <= 1'b0;
        end else begin
            load <= chg1 | chg2;
        end
    end

    motor_slew_channel #(
        .SLEW_STEP  (SLEW_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_ch1 (
        .clk       (clk),
        .reset     (reset),
        .step_tick (step_tick),
        .estop     (estop),
        .resume    (accept),
        .target    (tgt1),
        .setpoint  (sp1),
        .changed   (chg1),
        .state     (ch1_state)
    );

    motor_slew_channel #(
        .SLEW_STEP  (SLEW_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_ch2 (
        .clk       (clk),
        .reset     (reset),
        .step_tick (step_tick),
        .estop     (estop),
        .resume    (accept),
        .target    (tgt2),
        .setpoint  (sp2),
        .changed   (chg2),
        .state     (ch2_state)
    );

    // Both channels enter and leave HALT on the same edges.
    assign halted      = (ch1_state == HALT) | (ch2_state == HALT);
    assign motor1_sign = sp1.sign;
    assign motor1_mag  = sp1.mag;
    assign motor2_sign = sp2.sign;
    assign motor2_mag  = sp2.mag;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
module tb_motor_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_motor1;
  logic [7:0] cmd_motor2;
  logic       estop;
  logic       motor1_sign;
  logic [6:0] motor1_mag;
  logic       motor2_sign;
  logic [6:0] motor2_mag;
  logic       load;
  logic       timeout_flag;
  logic       halted;

  int tests_run    = 0;
  int tests_failed = 0;

  motor_cmd_sequencer #(
    .STEP_DIV   (4),
    .SLEW_STEP  (4),
    .DEAD_TICKS (2),
    .WDT_STEPS  (20),
    .MAX_MAG    (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_motor1   (cmd_motor1),
    .cmd_motor2   (cmd_motor2),
    .estop        (estop),
    .motor1_sign  (motor1_sign),
    .motor1_mag   (motor1_mag),
    .motor2_sign  (motor2_sign),
    .motor2_mag   (motor2_mag),
    .load         (load),
    .timeout_flag (timeout_flag),
    .halted       (halted)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  // checking and driver tasks
  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] m1, input logic [7:0] m2);
    @(negedge clk);
    cmd_motor1 = m1;
    cmd_motor2 = m2;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Returns the number of negedges until load is seen, or -1 if the budget runs out.
  task automatic wait_load(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (load === 1'b1) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic count_loads(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (load === 1'b1) cnt++;
    end
  endtask

  initial begin
    int w;
    int n;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_motor1 = 8'h00;
    cmd_motor2 = 8'h00;
    estop      = 1'b0;

    // ---- 1: reset state, mid-ramp async reset, quiet after release
    repeat (3) @(negedge clk);
    check("rst_m1_mag", motor1_mag, 0);
    check("rst_m1_sign", motor1_sign, 0);
    check("rst_m2_mag", motor2_mag, 0);
    check("rst_m2_sign", motor2_sign, 0);
    check("rst_load", load, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_halted", halted, 0);
    reset = 1'b1;
    count_loads(12, n);
    check("post_rst_no_load", n, 0);

    send_cmd(8'h28, 8'h00);
    wait_load(12, w);
    check("t1_ramp_mag4", motor1_mag, 4);
    wait_load(12, w);
    check("t1_ramp_mag8", motor1_mag, 8);
    #2 reset = 1'b0;
    #1;
    check("t1_async_m1_mag", motor1_mag, 0);
    check("t1_async_load", load, 0);
    @(negedge clk);
    reset = 1'b1;
    count_loads(16, n);
    check("t1_release_no_load", n, 0);

    // ---- 2: ramp 0 -> +40, one load per tick, then hold
    send_cmd(8'h28, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      wait_load(12, w);
      check("t2_load_seen", int'(w > 0), 1);
      check("t2_m1_mag", motor1_mag, 4 * i);
      check("t2_m1_sign", motor1_sign, 0);
    end
    count_loads(16, n);
    check("t2_hold_no_load", n, 0);
    check("t2_hold_mag", motor1_mag, 40);
    check("t2_m2_idle", motor2_mag, 0);

    // ---- 3: +40 -> +8, then reversal to -8 through a 2-tick dwell
    send_cmd(8'h08, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      wait_load(12, w);
      check("t3_down_mag", motor1_mag, 40 - 4 * i);
    end
    send_cmd(8'h88, 8'h00);
    wait_load(12, w);
    check("t3_rev_mag4", motor1_mag, 4);
    check("t3_rev_sign4", motor1_sign, 0);
    wait_load(12, w);
    check("t3_rev_mag0", motor1_mag, 0);
    check("t3_rev_sign0", motor1_sign, 0);
    wait_load(30, w);
    check("t3_dwell_gap", w, 12);
    check("t3_neg_sign", motor1_sign, 1);
    check("t3_neg_mag4", motor1_mag, 4);
    wait_load(12, w);
    check("t3_neg_gap", w, 4);
    check("t3_neg_mag8", motor1_mag, 8);
    count_loads(12, n);
    check("t3_hold_no_load", n, 0);

    // ---- 4: clamp 0x7F -> 100 on motor 2, then negative zero ramps to +0
    send_cmd(8'h88, 8'h7F);
    for (int i = 1; i <= 25; i++) begin
      wait_load(12, w);
      check("t4_up_mag", motor2_mag, 4 * i);
      if (i == 12) send_cmd(8'h88, 8'h7F);
    end
    count_loads(16, n);
    check("t4_clamp_no_load", n, 0);
    check("t4_clamp_mag", motor2_mag, 100);
    check("t4_m1_sign_kept", motor1_sign, 1);
    check("t4_m1_mag_kept", motor1_mag, 8);
    send_cmd(8'h88, 8'h80);
    for (int i = 1; i <= 25; i++) begin
      wait_load(12, w);
      check("t4_down_mag", motor2_mag, 100 - 4 * i);
      check("t4_down_sign", motor2_sign, 0);
      if (i == 12) send_cmd(8'h88, 8'h80);
    end

    // ---- 5: -8 -> +40, then watchdog expiry 20 ticks after the command
    send_cmd(8'h28, 8'h00);
    wait_load(12, w);
    check("t5_rev_sign", motor1_sign, 1);
    check("t5_rev_mag4", motor1_mag, 4);
    wait_load(12, w);
    check("t5_rev_mag0", motor1_mag, 0);
    wait_load(30, w);
    check("t5_dwell_gap", w, 12);
    check("t5_pos_mag4", motor1_mag, 4);
    check("t5_pos_sign", motor1_sign, 0);
    for (int i = 2; i <= 10; i++) begin
      wait_load(12, w);
      check("t5_up_mag", motor1_mag, 4 * i);
    end
    check("t5_no_timeout_yet", timeout_flag, 0);
    wait_load(40, w);
    check("t5_expiry_gap", w, 28);
    check("t5_timeout_set", timeout_flag, 1);
    check("t5_first_down", motor1_mag, 36);
    for (int i = 1; i <= 9; i++) begin
      wait_load(12, w);
      check("t5_down_mag", motor1_mag, 36 - 4 * i);
    end
    check("t5_timeout_held", timeout_flag, 1);
    @(negedge clk);
    check("t5_flag_before_cmd", timeout_flag, 1);
    cmd_motor1 = 8'h20;
    cmd_motor2 = 8'h00;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    check("t5_flag_cleared", timeout_flag, 0);

    // ---- 6: e-stop at +24, ignored command, release by a new command
    for (int i = 1; i <= 6; i++) begin
      wait_load(20, w);
      check("t6_up_mag", motor1_mag, 4 * i);
    end
    estop = 1'b1;
    @(negedge clk);
    check("t6_stop_m1_mag", motor1_mag, 0);
    check("t6_stop_m2_mag", motor2_mag, 0);
    check("t6_stop_halted", halted, 1);
    check("t6_stop_load", load, 1);
    count_loads(4, n);
    check("t6_single_load", n, 0);
    send_cmd(8'h40, 8'h40);
    count_loads(12, n);
    check("t6_cmd_ignored_load", n, 0);
    check("t6_cmd_ignored_mag", motor1_mag, 0);
    estop = 1'b0;
    count_loads(8, n);
    check("t6_release_no_load", n, 0);
    check("t6_still_halted", halted, 1);
    send_cmd(8'h10, 8'h00);
    check("t6_unhalted", halted, 0);
    wait_load(12, w);
    check("t6_no_dwell", int'(w >= 1 && w <= 4), 1);
    check("t6_ramp_mag4", motor1_mag, 4);
    for (int i = 2; i <= 4; i++) begin
      wait_load(12, w);
      check("t6_ramp_mag", motor1_mag, 4 * i);
    end
    count_loads(12, n);
    check("t6_hold_no_load", n, 0);
    check("t6_hold_mag", motor1_mag, 16);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
